// File: rtl/relay_ctrl_pkg.sv
// ============================================================================
// Module   : relay_ctrl_pkg
// Purpose  : Shared fetch-state encoding, LED codes and timing default for the
//            relay-computer control sequencers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package relay_ctrl_pkg;

    localparam int PHASE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        READ   = 3'd2,
        LOAD   = 3'd3,
        INCR   = 3'd4,
        EXEC   = 3'd5,
        HALTED = 3'd6
    } fetch_state_t;

    localparam logic [2:0] LED_IDLE   = 3'd0;
    localparam logic [2:0] LED_ADDR   = 3'd1;
    localparam logic [2:0] LED_READ   = 3'd2;
    localparam logic [2:0] LED_LOAD   = 3'd3;
    localparam logic [2:0] LED_INCR   = 3'd4;
    localparam logic [2:0] LED_EXEC   = 3'd5;
    localparam logic [2:0] LED_HALTED = 3'd6;

    function automatic logic [2:0] state_led_code(input fetch_state_t s);
        logic [2:0] code;
        code = LED_IDLE;
        case (s)
            IDLE:    code = LED_IDLE;
            ADDR:    code = LED_ADDR;
            READ:    code = LED_READ;
            LOAD:    code = LED_LOAD;
            INCR:    code = LED_INCR;
            EXEC:    code = LED_EXEC;
            HALTED:  code = LED_HALTED;
            default: code = LED_IDLE;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Purpose  : Per-state dwell counter; restarts on state entry and saturates
//            once the PHASE_CYCLES dwell has been reached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    output logic expire_o,
    output logic first_o
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          first_q;

    // Saturating so a stretched state (memory wait) keeps reporting expiry.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            first_q <= 1'b0;
        end else begin
            count_q <= count_d;
            first_q <= clr_i;
        end
    end

    assign expire_o = (count_q == LAST);
    assign first_o  = first_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_sequencer.sv
// ============================================================================
// Module   : inst_fetch_sequencer
// Purpose  : Fetch-cycle control FSM around the INST register; drives Ctrl_Bus
//            fetch strobes and LED_Bus status, then hands off to execute.
// Build option: FETCH_WAIT_EN adds mem_ready and stretches READ until it is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_sequencer
    import relay_ctrl_pkg::*;
#(
    parameter int PHASE_CYCLES = PHASE_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             exec_done,
`ifdef FETCH_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             sel_pc,
    output logic             mem_rd,
    output logic             ld_inst,
    output logic             ld_inc,
    output logic             sel_inc,
    output logic             ld_pc,
    output logic             exec_start,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state_led,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [CNT_W-1:0] fetch_count_q;
    logic [CNT_W-1:0] fetch_count_d;
    logic             phase_done;
    logic             state_first;
    logic             read_ok;

`ifdef FETCH_WAIT_EN
    assign read_ok = phase_done & mem_ready;
`else
    assign read_ok = phase_done;
`endif

    phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (state_d != state_q),
        .expire_o (phase_done),
        .first_o  (state_first)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_count_d = fetch_count_q;
        sel_pc        = 1'b0;
        mem_rd        = 1'b0;
        ld_inst       = 1'b0;
        ld_inc        = 1'b0;
        sel_inc       = 1'b0;
        ld_pc         = 1'b0;
        exec_start    = 1'b0;
        busy          = 1'b1;
        halted        = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (run || step) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                sel_pc = 1'b1;
                if (phase_done) begin
                    state_d = READ;
                end
            end
            READ: begin
                sel_pc = 1'b1;
                mem_rd = 1'b1;
                if (read_ok) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sel_pc  = 1'b1;
                mem_rd  = 1'b1;
                ld_inst = 1'b1;
                ld_inc  = 1'b1;
                if (phase_done) begin
                    state_d = INCR;
                end
            end
            INCR: begin
                sel_inc = 1'b1;
                ld_pc   = 1'b1;
                if (phase_done) begin
                    state_d       = EXEC;
                    fetch_count_d = fetch_count_q + 1'b1;
                end
            end
            EXEC: begin
                exec_start = state_first;
                // run is resampled here so a dropped run finishes this instruction only.
                if (exec_done) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (run) begin
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign state_led   = state_led_code(state_q);
    assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_sequencer.sv
// Bench for inst_fetch_sequencer: directed scenarios plus random traffic, all
// compared each clock against a timeline model of the fetch/execute cycle.
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_sequencer;

    localparam int PC    = 2;
    localparam int CNT_W = 16;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, run, step, halt, exec_done, mem_ready;
    logic sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc;
    logic exec_start, busy, halted;
    logic [2:0]       state_led;
    logic [CNT_W-1:0] fetch_count;

    inst_fetch_sequencer #(
        .PHASE_CYCLES (PC),
        .CNT_W        (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .halt        (halt),
        .exec_done   (exec_done),
`ifdef FETCH_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .sel_pc      (sel_pc),
        .mem_rd      (mem_rd),
        .ld_inst     (ld_inst),
        .ld_inc      (ld_inc),
        .sel_inc     (sel_inc),
        .ld_pc       (ld_pc),
        .exec_start  (exec_start),
        .busy        (busy),
        .halted      (halted),
        .state_led   (state_led),
        .fetch_count (fetch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: a fetch is 4*PC clocks indexed by m_t, then one EXEC window.
    int               m_mode  = M_IDLE;
    int               m_t     = 0;
    logic [CNT_W-1:0] m_cnt   = '0;
    bit               m_first = 1'b0;

    task automatic model_step();
        logic mr_eff;
`ifdef FETCH_WAIT_EN
        mr_eff = mem_ready;
`else
        mr_eff = 1'b1;
`endif
        if (reset) begin
            m_mode  = M_IDLE;
            m_cnt   = '0;
            m_first = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (run || step) begin
                        m_mode = M_FETCH;
                        m_t    = 0;
                    end
                end
                M_FETCH: begin
                    if (m_t == 2*PC-1 && !mr_eff) begin
                        m_t = m_t;
                    end else if (m_t == 4*PC-1) begin
                        m_mode  = M_EXEC;
                        m_first = 1'b1;
                        m_cnt   = m_cnt + 1'b1;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                M_EXEC: begin
                    m_first = 1'b0;
                    if (exec_done) begin
                        if (halt) begin
                            m_mode = M_HALT;
                        end else if (run) begin
                            m_mode = M_FETCH;
                            m_t    = 0;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: m_mode = M_HALT;
            endcase
        end
    endtask

    function automatic logic [5:0] exp_strobes();
        int ph;
        ph = m_t / PC;
        if (m_mode != M_FETCH) return 6'b0;
        // {sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc}
        case (ph)
            0:       return 6'b100000;
            1:       return 6'b110000;
            2:       return 6'b111100;
            default: return 6'b000011;
        endcase
    endfunction

    function automatic logic [5:0] exp_status();
        logic [2:0] led;
        case (m_mode)
            M_IDLE:  led = 3'd0;
            M_FETCH: led = 3'(1 + m_t / PC);
            M_EXEC:  led = 3'd5;
            default: led = 3'd6;
        endcase
        // {exec_start, busy, halted, state_led}
        return {(m_mode == M_EXEC) && m_first,
                (m_mode == M_FETCH) || (m_mode == M_EXEC),
                (m_mode == M_HALT), led};
    endfunction

    int c_selpc, c_memrd, c_ldinst, c_ldpc, c_xs;

    task automatic clear_counts();
        c_selpc = 0; c_memrd = 0; c_ldinst = 0; c_ldpc = 0; c_xs = 0;
    endtask

    task automatic tick(input logic rs, input logic r, input logic s,
                        input logic h, input logic ed, input logic mr);
        reset = rs; run = r; step = s; halt = h; exec_done = ed; mem_ready = mr;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_eq("strobes", 32'({sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc}), 32'(exp_strobes()));
        check_eq("status", 32'({exec_start, busy, halted, state_led}), 32'(exp_status()));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_cnt));
        check_eq("bus_safe", 32'({sel_pc & sel_inc, ld_inst & ~mem_rd, ld_pc & sel_pc}), 32'd0);
        c_selpc  += int'(sel_pc);
        c_memrd  += int'(mem_rd);
        c_ldinst += int'(ld_inst);
        c_ldpc   += int'(ld_pc);
        c_xs     += int'(exec_start);
    endtask

    initial begin
        bit found;
        bit dropped;
        int n_idle;
        int rd;
        logic mr;

        reset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0; exec_done = 1'b0; mem_ready = 1'b1;
        clear_counts();
        @(negedge clock);

        // Reset, then quiet idle
        repeat (3) tick(1, 0, 0, 0, 0, 1);
        repeat (10) tick(0, 0, 0, 0, 0, 1);
        check_eq("t1_led", 32'(state_led), 32'd0);
        check_eq("t1_count", 32'(fetch_count), 32'd0);

        // Single step with delayed exec_done
        clear_counts();
        tick(0, 0, 1, 0, 0, 1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exec_start) begin
                found = 1'b1;
                break;
            end
            tick(0, 0, 0, 0, 0, 1);
        end
        check_eq("t2_exec_start_seen", 32'(found), 32'd1);
        repeat (2) tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1, 1);
        repeat (3) tick(0, 0, 0, 0, 0, 1);
        check_eq("t2_sel_pc_clks", 32'(c_selpc), 32'(3*PC));
        check_eq("t2_mem_rd_clks", 32'(c_memrd), 32'(2*PC));
        check_eq("t2_ld_inst_clks", 32'(c_ldinst), 32'(PC));
        check_eq("t2_ld_pc_clks", 32'(c_ldpc), 32'(PC));
        check_eq("t2_exec_starts", 32'(c_xs), 32'd1);
        check_eq("t2_led_idle", 32'(state_led), 32'd0);
        check_eq("t2_count", 32'(fetch_count), 32'd1);

        // Free run, immediate exec_done, five instructions
        clear_counts();
        dropped = 1'b0;
        n_idle  = 0;
        found   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_mode == M_FETCH && m_cnt == 16'd5) dropped = 1'b1;
            tick(0, !dropped, 0, 0, 1, 1);
            if (!dropped && state_led == 3'd0) n_idle++;
            if (dropped && m_mode == M_IDLE) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t3_returned_idle", 32'(found), 32'd1);
        check_eq("t3_idle_gaps", 32'(n_idle), 32'd0);
        check_eq("t3_exec_starts", 32'(c_xs), 32'd5);
        check_eq("t3_count", 32'(fetch_count), 32'd6);

        // Halt on the third instruction
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(0, 1, 0, (m_mode == M_EXEC && m_cnt == 16'd9), 1, 1);
            if (m_mode == M_HALT) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t4_halt_reached", 32'(found), 32'd1);
        check_eq("t4_halted", 32'(halted), 32'd1);
        check_eq("t4_led", 32'(state_led), 32'd6);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        check_eq("t4_still_halted", 32'({halted, busy, state_led}), 32'({1'b1, 1'b0, 3'd6}));
        check_eq("t4_count_frozen", 32'(fetch_count), 32'd9);

        // Reset during LOAD
        tick(1, 0, 0, 0, 0, 1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 0, 0, 1, 1);
            if (ld_inst) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t5_load_seen", 32'(found), 32'd1);
        tick(1, 1, 0, 0, 0, 1);
        check_eq("t5_ld_inst", 32'(ld_inst), 32'd0);
        check_eq("t5_led", 32'(state_led), 32'd0);
        check_eq("t5_count", 32'(fetch_count), 32'd0);
        tick(0, 0, 0, 0, 0, 1);

        // READ length with memory slow to respond
        rd = 0;
        mr = 1'b0;
        tick(0, 0, 1, 0, 0, mr);
        for (int i = 0; i < 60; i++) begin
            if (mem_rd && !ld_inst) rd++;
            if (exec_start) break;
            if (rd == 6) mr = 1'b1;
            tick(0, 0, 0, 0, 0, mr);
        end
`ifdef FETCH_WAIT_EN
        check_eq("t6_read_clks", 32'(rd), 32'd6);
`else
        check_eq("t6_read_clks", 32'(rd), 32'(PC));
`endif
        tick(0, 0, 0, 0, 1, 1);
        check_eq("t6_back_idle", 32'(state_led), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
